pp3_sync_fifo: RTL

PP3_SYNC_FIFO -- requirements
Module: pp3_sync_fifo

---
 rtl/pp3_sync_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/pp3_sync_fifo.sv
// Synchronous FIFO with registered read data, registered full/empty/count
// and sticky overflow/underflow flags. All flops use synchronous reset only.
module pp3_sync_fifo #(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 4,
    parameter logic INIT  = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         d_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         q_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o,
    output logic                     udf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic             rdOk;
    logic             wrOk;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
    assign rdOk = en_i & rd_i & ~empty_q;
    assign wrOk = en_i & wr_i & (~full_q | rdOk);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (wrOk) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rdOk) begin
            rptr_d = rptr_q + AW'(1);
            q_d    = mem[rptr_q];
        end

        if (wrOk && !rdOk) begin
            count_d = count_q + CW'(1);
        end else if (rdOk && !wrOk) begin
            count_d = count_q - CW'(1);
        end

        if (en_i && wr_i && !wrOk) begin
            ovf_d = 1'b1;
        end
        if (en_i && rd_i && empty_q) begin
            udf_d = 1'b1;
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            q_q     <= {WIDTH{INIT}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            q_q     <= q_d;
        end
    end

    // Storage has no reset; nothing reads an entry before it has been written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wrOk) begin
            mem[wptr_q] <= d_i;
        end
    end

    assign q_o     = q_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

endmodule
